// File: rtl/tt_seq_alu.sv
// rtl/tt_seq_alu.sv - sequential add/sub/shift-add multiply/saturating accumulate ALU
module tt_seq_alu #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [1:0]         mode,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               flag_zero,
    output logic               flag_c
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_MUL = 2'b10;
    localparam logic [1:0] MODE_ACC = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [RW-1:0]    acc;
    logic [RW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [RW-1:0]    prod;
    logic [CW-1:0]    mul_cnt;

    logic             accept;
    logic             mul_last;
    logic [RW-1:0]    a_ext;
    logic [RW-1:0]    b_ext;
    logic [RW-1:0]    add_res;
    logic [RW-1:0]    sub_res;
    logic [RW-1:0]    acc_base;
    logic [RW:0]      acc_sum;
    logic             acc_sat;
    logic [RW-1:0]    acc_next;
    logic [RW-1:0]    prod_next;
    logic [RW-1:0]    op_res;
    logic             op_c;

    // Ready only in IDLE; forced low while reset is held so nothing slips in.
    assign in_ready  = (state == S_IDLE) && !reset;
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign mul_last  = (mul_cnt == CW'(WIDTH - 1));

    assign a_ext = {{WIDTH{1'b0}}, op_a};
    assign b_ext = {{WIDTH{1'b0}}, op_b};

    // The sum of two WIDTH-bit values needs WIDTH+1 bits, which always fits in RW.
    assign add_res = a_ext + b_ext;
    assign sub_res = a_ext - b_ext;

    // A clear on the same edge as an ACC accept takes effect before the add.
    assign acc_base  = acc_clr ? '0 : acc;
    assign acc_sum   = {1'b0, acc_base} + {1'b0, a_ext};
    assign acc_sat   = acc_sum[RW];
    assign acc_next  = acc_sat ? '1 : acc_sum[RW-1:0];

    // One multiplier bit per BUSY edge, LSB first.
    assign prod_next = prod + (mplier[0] ? mcand : '0);

    // Single-cycle result and carry/borrow/saturate flag for non-MUL modes.
    always_comb begin
        op_res = '0;
        op_c   = 1'b0;
        case (mode)
            MODE_ADD: begin
                op_res = add_res;
                op_c   = add_res[WIDTH];
            end
            MODE_SUB: begin
                op_res = sub_res;
                op_c   = (op_a < op_b);
            end
            MODE_ACC: begin
                op_res = acc_next;
                op_c   = acc_sat;
            end
            default: begin
                op_res = '0;
                op_c   = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: MUL detours through BUSY, everything else goes straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (mode == MODE_MUL) ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (mul_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add iterations, accumulator and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            mul_cnt   <= '0;
            result    <= '0;
            flag_zero <= 1'b0;
            flag_c    <= 1'b0;
        end else begin
            if (acc_clr) begin
                acc <= '0;
            end
            if (accept) begin
                if (mode == MODE_MUL) begin
                    mcand   <= a_ext;
                    mplier  <= op_b;
                    prod    <= '0;
                    mul_cnt <= '0;
                end else begin
                    result    <= op_res;
                    flag_c    <= op_c;
                    flag_zero <= (op_res == '0);
                    if (mode == MODE_ACC) begin
                        acc <= acc_next;
                    end
                end
            end else if (state == S_BUSY) begin
                prod    <= prod_next;
                mcand   <= mcand << 1;
                mplier  <= mplier >> 1;
                mul_cnt <= mul_last ? '0 : mul_cnt + 1'b1;
                if (mul_last) begin
                    result    <= prod_next;
                    flag_c    <= 1'b0;
                    flag_zero <= (prod_next == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_seq_alu.sv
// tb/tb_tt_seq_alu.sv - self-checking bench for tt_seq_alu
module tb_tt_seq_alu;

    localparam int W    = 3;
    localparam int MAXV = (1 << (2 * W)) - 1;
    localparam int MODV = 1 << (2 * W);

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [1:0]     mode;
    logic           acc_clr;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           flag_zero;
    logic           flag_c;

    int n_checks;
    int n_fail;
    int model_acc;

    tt_seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mode      (mode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_zero (flag_zero),
        .flag_c    (flag_c)
    );

    always #5 clk = ~clk;

    // Reference behaviour straight from the arithmetic rules of each mode.
    function automatic void model(input int m, input int a, input int b, input bit clr,
                                  inout int acc, output int r, output bit c, output int lat);
        int s;
        lat = (m == 2) ? W : 0;
        case (m)
            0: begin r = a + b; c = (a + b) >= (1 << W); end
            1: begin r = (a - b + MODV) % MODV; c = (a < b); end
            2: begin r = a * b; c = 1'b0; end
            default: begin
                if (clr) acc = 0;
                s = acc + a;
                c = (s > MAXV);
                r = c ? MAXV : s;
                acc = r;
            end
        endcase
    endfunction

    // Issue one operation, wait for its result, then consume it after 'hold' stall cycles.
    task automatic run_op(input int m, input int a, input int b, input bit clr, input int hold,
                          output int res, output bit z, output bit c, output int lat);
        int w;
        int mm;
        int aa;
        int bb;
        mm = m; aa = a; bb = b;
        in_valid = 1'b1;
        mode = mm[1:0];
        op_a = aa[W-1:0];
        op_b = bb[W-1:0];
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        acc_clr = clr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_clr = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid || w >= 50) lat = -1;
        res = int'(result);
        z = flag_zero;
        c = flag_c;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || result !== '0 || flag_zero !== 1'b0 || flag_c !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ov=%b res=%0d z=%b c=%b, want 0 0 0 0",
                     out_valid, result, flag_zero, flag_c);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        model_acc = 0;
    endtask

    task automatic test_add();
        int r; bit z; bit c; int lat;
        run_op(0, 7, 7, 1'b0, 0, r, z, c, lat);
        n_checks++;
        if (r !== 14 || c !== 1'b1 || z !== 1'b0 || lat !== 0) begin
            n_fail++;
            $display("FAIL add_7_7: got res=%0d c=%b z=%b lat=%0d, want 14 1 0 0", r, c, z, lat);
        end
        run_op(0, 0, 0, 1'b0, 0, r, z, c, lat);
        n_checks++;
        if (r !== 0 || z !== 1'b1 || c !== 1'b0) begin
            n_fail++;
            $display("FAIL add_0_0: got res=%0d z=%b c=%b, want 0 1 0", r, z, c);
        end
    endtask

    task automatic test_sub();
        int r; bit z; bit c; int lat;
        run_op(1, 2, 5, 1'b0, 0, r, z, c, lat);
        n_checks++;
        if (r !== 61 || c !== 1'b1 || z !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_2_5: got res=%0d c=%b z=%b, want 61 1 0", r, c, z);
        end
        run_op(1, 5, 5, 1'b0, 0, r, z, c, lat);
        n_checks++;
        if (r !== 0 || z !== 1'b1 || c !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_5_5: got res=%0d z=%b c=%b, want 0 1 0", r, z, c);
        end
    endtask

    task automatic test_mul();
        in_valid = 1'b1; mode = 2'b10; op_a = 3'd7; op_b = 3'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_busy_%0d: got in_ready=%b out_valid=%b, want 0 0",
                         k, in_ready, out_valid);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (out_valid !== 1'b1 || result !== 6'd49 || flag_c !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_7_7: got ov=%b res=%0d c=%b rdy=%b, want 1 49 0 0",
                     out_valid, result, flag_c, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int w;
        in_valid = 1'b1; mode = 2'b10; op_a = 3'd5; op_b = 3'd6;
        @(posedge clk); #1;
        mode = 2'b00; op_a = 3'd1; op_b = 3'd2;
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk); #1; w++;
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || result !== 6'd30 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got ov=%b res=%0d rdy=%b, want 1 30 0",
                         k, out_valid, result, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 6'd30) begin
            n_fail++;
            $display("FAIL bp_exit: got ov=%b rdy=%b res=%0d, want 0 1 30",
                     out_valid, in_ready, result);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 6'd3) begin
            n_fail++;
            $display("FAIL bp_next_add: got ov=%b res=%0d, want 1 3", out_valid, result);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_acc();
        int r; bit z; bit c; int lat;
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            run_op(3, 7, 0, 1'b0, 0, r, z, c, lat);
            n_checks++;
            if (r !== ((7 * k > MAXV) ? MAXV : 7 * k) || c !== (7 * k > MAXV) || lat !== 0) begin
                n_fail++;
                $display("FAIL acc_step_%0d: got res=%0d c=%b lat=%0d, want %0d %b 0",
                         k, r, c, lat, (7 * k > MAXV) ? MAXV : 7 * k, (7 * k > MAXV));
            end
        end
        run_op(3, 1, 0, 1'b1, 0, r, z, c, lat);
        n_checks++;
        if (r !== 1 || c !== 1'b0) begin
            n_fail++;
            $display("FAIL acc_clr_same_edge: got res=%0d c=%b, want 1 0", r, c);
        end
        model_acc = 1;
    endtask

    task automatic test_reset_mid_mul();
        int r; bit z; bit c; int lat;
        in_valid = 1'b1; mode = 2'b10; op_a = 3'd7; op_b = 3'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_mul: got ov=%b res=%0d rdy=%b, want 0 0 0",
                     out_valid, result, in_ready);
        end
        reset = 1'b0;
        model_acc = 0;
        repeat (W + 1) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_resume: got ov=%b want 0", out_valid);
        end
        run_op(0, 1, 0, 1'b0, 0, r, z, c, lat);
        n_checks++;
        if (r !== 1 || lat !== 0) begin
            n_fail++;
            $display("FAIL post_reset_add: got res=%0d lat=%0d, want 1 0", r, lat);
        end
        run_op(3, 2, 0, 1'b0, 0, r, z, c, lat);
        model_acc = 2;
        n_checks++;
        if (r !== 2) begin
            n_fail++;
            $display("FAIL post_reset_acc: got res=%0d want 2 (acc not cleared)", r);
        end
    endtask

    task automatic test_sweep();
        int r; bit z; bit c; int lat;
        int er; bit ec; int elat;
        bit clr;
        for (int m = 0; m < 4; m++) begin
            for (int a = 0; a < (1 << W); a++) begin
                for (int b = 0; b < (1 << W); b++) begin
                    clr = (m == 3) && ($urandom_range(0, 7) == 0);
                    model(m, a, b, clr, model_acc, er, ec, elat);
                    run_op(m, a, b, clr, $urandom_range(0, 2), r, z, c, lat);
                    n_checks++;
                    if (r !== er || c !== ec || z !== (er == 0) || lat !== elat) begin
                        n_fail++;
                        $display("FAIL sweep m=%0d a=%0d b=%0d: got res=%0d c=%b z=%b lat=%0d, want %0d %b %b %0d",
                                 m, a, b, r, c, z, lat, er, ec, (er == 0), elat);
                    end
                end
            end
        end
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0;
        mode = 2'b00; acc_clr = 1'b0; out_ready = 1'b0;
        n_checks = 0; n_fail = 0; model_acc = 0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_backpressure();
        test_acc();
        test_reset_mid_mul();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
